fifo_write_arbiter: RTL
=======================

Name: fifo_write_arbiter

Overview:
- Round-robin arbiter sharing the single write port of async_fifo among NREQ requesters.
- Sits in the write clock domain. clk is wired to the FIFO's write_clk, and p_write_en/p_write_data/p_write_full connect directly to the FIFO write side.
- Grants are packet-atomic: a granted requester owns the port until its last beat or until MAX_BURST beats, whichever comes first.

Parameters:
- BITS, 32, data width; must equal the FIFO's BITS.
- NREQ, 4, number of requesters (1..16).
- MAX_BURST, 8, maximum beats per grant (1..256).

Ports:
- clk  input  1  clock (the FIFO's write_clk).
- rstn  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester beat valid.
- req_last  input  NREQ  per-requester last-beat-of-packet marker, qualified by req_valid.
- req_data  input  NREQ*BITS  per-requester data; requester i occupies bits [i*BITS +: BITS].
- req_ready  output  NREQ  per-requester ready; a beat is accepted when req_valid[i] && req_ready[i].
- p_write_en  output  1  FIFO write strobe.
- p_write_data  output  BITS  FIFO write data.
- p_write_full  input  1  FIFO full flag.
- grant_id  output  $clog2(NREQ) (min 1)  currently granted requester index.
- busy  output  1  high while in the BURST state.

Behaviour:
Reset
- Asynchronous on rstn low: state=IDLE, grant_id=0, busy=0, req_ready=0, beat_cnt=0.
- Round-robin pointer last_grant=NREQ-1, so requester 0 has first priority.
- Reset mid-burst: beats already written stay in the FIFO; no rollback.

Dataflow (combinational, zero latency)
- req_ready[i] = busy && (grant_id==i) && !p_write_full.
- p_write_en = |(req_valid & req_ready).
- p_write_data = req_data of grant_id while busy, else 0.
- A write is never issued while p_write_full=1.

FSM, state IDLE
- busy=0, req_ready=0.
- If any req_valid: select the first set bit scanning last_grant+1, last_grant+2, … mod NREQ.
- Register grant_id, clear beat_cnt, go to BURST.
- This gives one arbitration bubble cycle per grant.

FSM, state BURST
- Each accepted beat increments beat_cnt.
- The burst ends on an accepted beat where req_last=1, or where beat_cnt==MAX_BURST-1.
- On burst end: last_grant<=grant_id, go to IDLE.
- p_write_full=1 stalls: grant, beat_cnt and state are held.
- Granted requester drops req_valid mid-packet: grant is held (packet atomicity). No timeout.
- A packet longer than MAX_BURST is split. Its remainder re-arbitrates fairly and the requester resumes mid-packet when next granted.
- Non-granted requesters' valid/last/data are ignored.
- NREQ=1: same FSM, grant_id is always 0.

Requester obligations
- Hold req_data/req_last stable while req_valid=1 and req_ready=0.

Optional Feature:
- Macro: FIFO_ARB_STATS_EN.
- Defined: adds output beat_count (32 bits) and output stall_count (32 bits).
  - beat_count increments on every p_write_en.
  - stall_count increments every cycle with busy=1, p_write_full=1 and the granted req_valid=1.
  - Both wrap modulo 2^32 and clear on rstn.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset: assert rstn=0 with all req_valid=1 -> req_ready=0, p_write_en=0, busy=0, grant_id=0. After release, first grant is requester 0.
- Single packet: req 2 sends 3 beats 0xA0,0xA1,0xA2 (last on 3rd), FIFO not full -> IDLE 1 cycle, then p_write_en high 3 consecutive cycles with data in order, then busy=0.
- Round-robin: all 4 requesters continuously send 1-beat packets -> grant order 0,1,2,3,0,1,…; each write separated by one bubble cycle.
- Burst cap: MAX_BURST=8, req 1 sends a 20-beat packet while req 3 waits -> grants req1 (8 beats), req3, req1 (8), req3…, with req1 data contiguous and in order.
- Full stall: p_write_full=1 forced for 5 cycles mid-burst after beat 2 -> no p_write_en for those 5 cycles, grant_id unchanged, beat 3 written in the first cycle full drops.
- End-to-end: arbiter feeding async_fifo (write_clk/read_clk unrelated); 3 requesters × 50 tagged words each -> read side receives all 150 words, each requester's words in order, no loss or duplication. With FIFO_ARB_STATS_EN, beat_count=150.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// Round-robin, packet-atomic arbiter for the write port of async_fifo.
// Define FIFO_ARB_STATS_EN to add beat_count/stall_count outputs.
module fifo_write_arbiter #(
    parameter int BITS      = 32,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 8,
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_last,
    input  logic [NREQ*BITS-1:0] req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 p_write_en,
    output logic [BITS-1:0]      p_write_data,
    input  logic                 p_write_full,
    output logic [GW-1:0]        grant_id,
    output logic                 busy
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [31:0]          beat_count,
    output logic [31:0]          stall_count
`endif
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state;
    logic [GW-1:0]   last_grant;
    logic [CW-1:0]   beat_cnt;
    logic [GW-1:0]   pick;
    logic            g_valid;
    logic            g_last;
    logic [BITS-1:0] g_data;
    logic            burst_end;

    // First valid requester after last_grant, wrapping modulo NREQ.
    always_comb begin
        logic found;
        found = 1'b0;
        pick  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!found && req_valid[j] &&
                    (j == (int'(last_grant) + k) % NREQ)) begin
                    found = 1'b1;
                    pick  = GW'(j);
                end
            end
        end
    end

    always_comb begin
        g_valid   = 1'b0;
        g_last    = 1'b0;
        g_data    = '0;
        req_ready = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (grant_id == GW'(j)) begin
                g_valid      = req_valid[j];
                g_last       = req_last[j];
                g_data       = req_data[j*BITS +: BITS];
                req_ready[j] = busy && !p_write_full;
            end
        end
    end

    assign p_write_en   = |(req_valid & req_ready);
    assign p_write_data = busy ? g_data : '0;
    assign burst_end    = p_write_en &&
                          (g_last || beat_cnt == CW'(MAX_BURST - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            busy       <= 1'b0;
            grant_id   <= '0;
            last_grant <= GW'(NREQ - 1);
            beat_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        grant_id <= pick;
                        beat_cnt <= '0;
                        state    <= BURST;
                        busy     <= 1'b1;
                    end
                end
                BURST: begin
                    if (burst_end) begin
                        last_grant <= grant_id;
                        beat_cnt   <= '0;
                        state      <= IDLE;
                        busy       <= 1'b0;
                    end else if (p_write_en) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef FIFO_ARB_STATS_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            beat_count  <= '0;
            stall_count <= '0;
        end else begin
            if (p_write_en)
                beat_count <= beat_count + 32'd1;
            if (busy && p_write_full && g_valid)
                stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule
